lut_cmp_decoder: RTL

- Inverse of the comparison-to-LUT mapping: takes a k-input LUT truth table and decides whether it implements a single-threshold compare of the variable input against a constant.
- If it does, reports the canonical operation and constant.
- Scans the mask one entry per cycle, in ascending numeric order of the input value.
- Used by LUT-level analysis and equivalence checks to recover `$lt`/`$ge` cells from mapped `$lut` cells.

---
 rtl/lut_cmp_decoder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lut_cmp_decoder.sv
// lut_cmp_decoder
//   Decides whether a k-input LUT truth table is a single-threshold compare
//   of its input value against a constant. If it is, the block reports the
//   canonical form (lt or ge) and the threshold. The mask is scanned one entry
//   per cycle in ascending numeric order of the input value. The order is
//   either unsigned or two's complement.
//
//   Optional build macro: LUT_CMP_DEC_EARLY_EXIT_EN
//     When this macro is defined, the scan stops as soon as a second value
//     transition is seen. The result is the same as without the macro; only
//     the latency changes.
//
// Ports
//   CLK     in   clock, rising edge
//   SRST_N  in   synchronous active-low reset
//   START   in   begin decode, sampled only in IDLE
//   MASK    in   truth table; bit n is the LUT output for input pattern n
//   WIDTH   in   active LUT input count (1..LUT_WIDTH legal)
//   SIGNED  in   treat the input pattern as two's complement
//   BUSY    out  scan in progress
//   DONE    out  one-cycle pulse when the result is final
//   VALID   out  mask is a single-threshold comparison
//   ERR     out  illegal WIDTH
//   OP      out  0 = lt, 3 = ge
//   CONST   out  threshold, two's complement, LUT_WIDTH+1 bits
module lut_cmp_decoder #(
   parameter  int unsigned LUT_WIDTH = 4,
   localparam int unsigned MASK_W    = 1 << LUT_WIDTH
) (
   input  logic                 CLK,
   input  logic                 SRST_N,
   input  logic                 START,
   input  logic [MASK_W-1:0]    MASK,
   input  logic [2:0]           WIDTH,
   input  logic                 SIGNED,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 VALID,
   output logic                 ERR,
   output logic [1:0]           OP,
   output logic [LUT_WIDTH:0]   CONST
);

   localparam int unsigned CW    = LUT_WIDTH + 1;
   localparam logic [2:0]  MAX_W = 3'(LUT_WIDTH);
   localparam logic [1:0]  OP_LT = 2'd0;
   localparam logic [1:0]  OP_GE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t                 state_q, state_d;

   // Registered outputs
   logic                   busy_q,  busy_d;
   logic                   done_q,  done_d;
   logic                   valid_q, valid_d;
   logic                   err_q,   err_d;
   logic [1:0]             op_q,    op_d;
   logic [CW-1:0]          const_q, const_d;

   // Latched operands
   logic [MASK_W-1:0]      mask_q,   mask_d;
   logic [2:0]             width_q,  width_d;
   logic                   signed_q, signed_d;

   // Scan state
   logic [LUT_WIDTH-1:0]   step_q,  step_d;
   logic                   first_q, first_d;
   logic                   prev_q,  prev_d;
   logic [1:0]             tcnt_q,  tcnt_d;
   logic [LUT_WIDTH-1:0]   tpos_q,  tpos_d;

   // Scan datapath helpers
   logic [LUT_WIDTH-1:0]   sign_flip;
   logic [LUT_WIDTH-1:0]   idx;
   logic [LUT_WIDTH-1:0]   last_i;
   logic                   bit_cur;
   logic                   first_n;
   logic [1:0]             tcnt_n;
   logic [LUT_WIDTH-1:0]   tpos_n;
   logic [CW-1:0]          base;
   logic                   finish;

   // Address of the current entry. In signed mode the MSB of the step is
   // flipped, so that the most negative value is visited first.
   always_comb begin
      sign_flip = '0;
      if (signed_q) begin
         sign_flip = LUT_WIDTH'(1) << (width_q - 3'd1);
      end
      idx     = step_q ^ sign_flip;
      last_i  = LUT_WIDTH'((CW'(1) << width_q) - CW'(1));
      bit_cur = mask_q[idx];
      base    = '0;
      if (signed_q) begin
         base = CW'(0) - (CW'(1) << (width_q - 3'd1));
      end
   end

   // Transition tracking that includes the current entry
   always_comb begin
      first_n = first_q;
      tcnt_n  = tcnt_q;
      tpos_n  = tpos_q;
      if (step_q == '0) begin
         first_n = bit_cur;
         tcnt_n  = 2'd0;
         tpos_n  = '0;
      end else if (bit_cur != prev_q) begin
         if (tcnt_q != 2'd2) begin
            tcnt_n = tcnt_q + 2'd1;
         end
         if (tcnt_q == 2'd0) begin
            tpos_n = step_q;
         end
      end
   end

   // The scan ends after the last entry, or on a second transition when
   // early exit is built in.
   always_comb begin
      finish = (step_q == last_i);
`ifdef LUT_CMP_DEC_EARLY_EXIT_EN
      if (tcnt_n == 2'd2) begin
         finish = 1'b1;
      end
`endif
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      valid_d  = valid_q;
      err_d    = err_q;
      op_d     = op_q;
      const_d  = const_q;
      mask_d   = mask_q;
      width_d  = width_q;
      signed_d = signed_q;
      step_d   = step_q;
      first_d  = first_q;
      prev_d   = prev_q;
      tcnt_d   = tcnt_q;
      tpos_d   = tpos_q;

      unique case (state_q)
         IDLE: begin
            if (START) begin
               mask_d   = MASK;
               width_d  = WIDTH;
               signed_d = SIGNED;
               step_d   = '0;
               first_d  = 1'b0;
               prev_d   = 1'b0;
               tcnt_d   = 2'd0;
               tpos_d   = '0;
               valid_d  = 1'b0;
               op_d     = OP_LT;
               const_d  = '0;
               if ((WIDTH == 3'd0) || (WIDTH > MAX_W)) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  err_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = SCAN;
               end
            end
         end

         SCAN: begin
            first_d = first_n;
            prev_d  = bit_cur;
            tcnt_d  = tcnt_n;
            tpos_d  = tpos_n;
            step_d  = step_q + LUT_WIDTH'(1);
            if (finish) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = FIN;
               if (tcnt_n == 2'd2) begin
                  valid_d = 1'b0;
                  op_d    = OP_LT;
                  const_d = '0;
               end else begin
                  valid_d = 1'b1;
                  // A transition inverts the polarity of the first entry:
                  // a true-then-false mask is lt, a false-then-true mask is ge.
                  op_d    = (first_n ^ (tcnt_n == 2'd1)) ? OP_GE : OP_LT;
                  const_d = (tcnt_n == 2'd1) ? (base + CW'(tpos_n)) : base;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (!SRST_N) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         op_q     <= '0;
         const_q  <= '0;
         mask_q   <= '0;
         width_q  <= '0;
         signed_q <= 1'b0;
         step_q   <= '0;
         first_q  <= 1'b0;
         prev_q   <= 1'b0;
         tcnt_q   <= '0;
         tpos_q   <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         op_q     <= op_d;
         const_q  <= const_d;
         mask_q   <= mask_d;
         width_q  <= width_d;
         signed_q <= signed_d;
         step_q   <= step_d;
         first_q  <= first_d;
         prev_q   <= prev_d;
         tcnt_q   <= tcnt_d;
         tpos_q   <= tpos_d;
      end
   end

   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign VALID = valid_q;
   assign ERR   = err_q;
   assign OP    = op_q;
   assign CONST = const_q;

endmodule
